// File: rtl/sram_arbiter.sv
// Arbiter sharing one single-port ZBT SRAM between a display read stream and a
// capture write stream. Grants one request per cycle, inserts idle cycles on
// bus direction changes, bounds write starvation, and returns read data with a
// valid strobe after the fixed SRAM pipeline latency.
module sram_arbiter #(
  parameter int READ_LATENCY  = 4,
  parameter int TURNAROUND    = 1,
  parameter int MAX_RD_STREAK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [19:0] rd_addr,
  output logic        rd_ack,
  output logic [17:0] rd_data,
  output logic        rd_valid,
  input  logic        wr_req,
  input  logic [19:0] wr_addr,
  input  logic [17:0] wr_data,
  output logic        wr_ack,
  output logic [19:0] mem_addr,
  output logic [17:0] mem_wdata,
  output logic        mem_we,
  input  logic [17:0] mem_rdata
);

  localparam int SW    = $clog2(MAX_RD_STREAK + 1);
  localparam int TW    = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;
  // The cycle that detects a direction change is itself the first idle cycle,
  // so the TURN state only covers the remaining TURNAROUND-1 cycles.
  localparam int TA_M1 = (TURNAROUND > 1) ? TURNAROUND - 1 : 0;

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);
  localparam logic [TW-1:0] TURN_LOAD  = TW'(TA_M1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;

  state_t                  state_q, state_d;
  logic                    dir_q, dir_d;        // last issued direction, 1 = write
  logic                    tgt_q, tgt_d;        // direction being turned towards
  logic                    pref_q, pref_d;      // first cycle after a turn: favour dir
  logic [TW-1:0]           turn_cnt_q, turn_cnt_d;
  logic [SW-1:0]           streak_q, streak_d;
  logic [READ_LATENCY-1:0] vsr_q;
  logic                    rd_valid_q;
  logic [17:0]             rd_data_q;
  logic [19:0]             mem_addr_q;
  logic [17:0]             mem_wdata_q;
  logic                    mem_we_q;
  logic                    win_wr;
  logic                    rd_grant, wr_grant;

  // Arbitration, turnaround sequencing and starvation counter next-state
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tgt_d      = tgt_q;
    pref_d     = 1'b0;
    turn_cnt_d = turn_cnt_q;
    streak_d   = streak_q;
    win_wr     = 1'b0;
    rd_grant   = 1'b0;
    wr_grant   = 1'b0;

    if (state_q == S_TURN) begin
      if (turn_cnt_q <= TW'(1)) begin
        turn_cnt_d = '0;
        dir_d      = tgt_q;
        pref_d     = 1'b1;
        state_d    = S_IDLE;
      end else begin
        turn_cnt_d = turn_cnt_q - TW'(1);
      end
    end else begin
      if (rd_req && wr_req) begin
        win_wr = pref_q ? dir_q : (streak_q == STREAK_MAX);
      end else begin
        win_wr = wr_req;
      end

      if (!rd_req && !wr_req) begin
        state_d = S_IDLE;
      end else if ((win_wr == dir_q) || (TURNAROUND == 0)) begin
        rd_grant = ~win_wr;
        wr_grant = win_wr;
        dir_d    = win_wr;
        state_d  = win_wr ? S_WR : S_RD;
      end else begin
        tgt_d = win_wr;
        if (TURNAROUND <= 1) begin
          dir_d   = win_wr;
          pref_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          turn_cnt_d = TURN_LOAD;
          state_d    = S_TURN;
        end
      end
    end

    if (!wr_req || wr_grant) begin
      streak_d = '0;
    end else if (rd_grant && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end
  end

  assign rd_ack = rd_grant & ~rst;
  assign wr_ack = wr_grant & ~rst;

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_q      <= 1'b0;
      tgt_q      <= 1'b0;
      pref_q     <= 1'b0;
      turn_cnt_q <= '0;
      streak_q   <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tgt_q      <= tgt_d;
      pref_q     <= pref_d;
      turn_cnt_q <= turn_cnt_d;
      streak_q   <= streak_d;
    end
  end

  // Command registers: loaded only on a grant, write enable pulses for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
    end else if (rd_grant) begin
      mem_addr_q  <= rd_addr;
      mem_we_q    <= 1'b0;
    end else if (wr_grant) begin
      mem_addr_q  <= wr_addr;
      mem_wdata_q <= wr_data;
      mem_we_q    <= 1'b1;
    end else begin
      mem_we_q    <= 1'b0;
    end
  end

  // Read return path: valid token travels with the SRAM pipeline, data captured on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      vsr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vsr_q      <= (vsr_q << 1) | READ_LATENCY'(rd_grant);
      rd_valid_q <= vsr_q[READ_LATENCY-1];
      if (vsr_q[READ_LATENCY-1]) begin
        rd_data_q <= mem_rdata;
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a cycle-level rule model.
module tb_sram_arbiter;

  localparam int RL = 4;
  localparam int TA = 1;
  localparam int MX = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_req, wr_req;
  logic [19:0] rd_addr, wr_addr;
  logic [17:0] wr_data, mem_rdata;
  logic        rd_ack, wr_ack, rd_valid, mem_we;
  logic [17:0] rd_data, mem_wdata;
  logic [19:0] mem_addr;

  sram_arbiter #(.READ_LATENCY(RL), .TURNAROUND(TA), .MAX_RD_STREAK(MX)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Second instance with no turnaround gap
  logic        b_rst, b_rd_req, b_wr_req;
  logic [19:0] b_rd_addr, b_wr_addr;
  logic [17:0] b_wr_data, b_mem_rdata;
  logic        b_rd_ack, b_wr_ack, b_rd_valid, b_mem_we;
  logic [17:0] b_rd_data, b_mem_wdata;
  logic [19:0] b_mem_addr;

  sram_arbiter #(.READ_LATENCY(RL), .TURNAROUND(0), .MAX_RD_STREAK(MX)) dut_b (
    .clk(clk), .rst(b_rst),
    .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_ack(b_rd_ack), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
    .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_ack(b_wr_ack),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );
  assign b_mem_rdata = 18'h0;

  // SRAM stand-in: read word is a fixed function of the address, delivered RL-1 cycles after the command
  function automatic logic [17:0] fdat(input logic [19:0] a);
    return a[17:0] ^ {a[19:18], 16'hA5C3};
  endfunction

  logic [19:0] apipe [3];
  initial for (int i = 0; i < 3; i++) apipe[i] = '0;
  always @(posedge clk) begin
    apipe[0] <= mem_addr;
    apipe[1] <= apipe[0];
    apipe[2] <= apipe[1];
  end
  assign mem_rdata = fdat(apipe[RL-2]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int due; logic [19:0] addr;} rd_t;
  rd_t         rq[$];
  bit          ready = 0;
  logic        m_dir, m_tgt, m_pref;
  int          m_blk, m_streak;
  logic        e_we;
  logic [19:0] e_addr;
  logic [17:0] e_wdata, e_rdata;

  always @(negedge clk) begin
    logic e_rd, e_wr, exp_v, ewin, nxt_pref;
    e_rd = 1'b0; e_wr = 1'b0; nxt_pref = 1'b0; ewin = 1'b0;
    exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    if (exp_v) e_rdata = fdat(rq[0].addr);
    if (!rst && ready) begin
      if (m_blk > 0) begin
        m_blk--;
        if (m_blk == 0) begin m_dir = m_tgt; nxt_pref = 1'b1; end
      end else if (rd_req || wr_req) begin
        if (rd_req && wr_req) ewin = m_pref ? m_dir : (m_streak == MX);
        else ewin = wr_req;
        if (ewin == m_dir || TA == 0) begin
          e_rd = ~ewin; e_wr = ewin; m_dir = ewin;
        end else begin
          m_tgt = ewin;
          if (TA <= 1) begin m_dir = ewin; nxt_pref = 1'b1; end
          else m_blk = TA - 1;
        end
      end
    end
    if (ready) begin
      chk("rd_ack", 32'(rd_ack), 32'(e_rd));
      chk("wr_ack", 32'(wr_ack), 32'(e_wr));
      chk("rd_valid", 32'(rd_valid), 32'(exp_v));
      chk("rd_data", 32'(rd_data), 32'(e_rdata));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      if (exp_v) void'(rq.pop_front());
      if (!wr_req || e_wr) m_streak = 0;
      else if (e_rd && m_streak < MX) m_streak++;
      if (e_rd) begin
        e_addr = rd_addr; e_we = 1'b0;
        rq.push_back('{cyc + 1 + RL, rd_addr});
      end else if (e_wr) begin
        e_addr = wr_addr; e_wdata = wr_data; e_we = 1'b1;
      end else begin
        e_we = 1'b0;
      end
      m_pref = nxt_pref;
    end
    if (rst) begin
      m_dir = 1'b0; m_tgt = 1'b0; m_pref = 1'b0; m_blk = 0; m_streak = 0;
      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      rq.delete();
      ready = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [19:0] a, output int g);
    bit done;
    done = 0; g = -1;
    rd_req = 1'b1; rd_addr = a;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (rd_ack) begin g = cyc; done = 1; end
      tick();
    end
    rd_req = 1'b0;
    if (!done) chk("read_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int g0, first_v, nv, nack, nwr, run, maxrun, g, vcnt;
    int runs[$];
    logic [17:0] vdat [16];
    logic rd_seen, wr_seen;

    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    b_rst = 1'b1; b_rd_req = 1'b0; b_wr_req = 1'b0; b_rd_addr = '0; b_wr_addr = '0; b_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; b_rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    tick();

    // Simultaneous first requests: read wins with streak 0
    rd_req = 1'b1; rd_addr = 20'h00100; wr_req = 1'b1; wr_addr = 20'h00200; wr_data = 18'h00111;
    @(negedge clk);
    chk("first_rd_ack", 32'(rd_ack), 32'(1));
    chk("first_wr_ack", 32'(wr_ack), 32'(0));
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (8) tick();

    // Reads only, addresses 0..7 back to back
    g0 = -1; first_v = -1; nv = 0; nack = 0;
    for (int k = 0; k < 16; k++) begin
      rd_req = (k < 8); rd_addr = 20'(k);
      @(negedge clk);
      if (rd_ack) begin nack++; if (g0 < 0) g0 = cyc; end
      if (rd_valid) begin
        if (first_v < 0) first_v = cyc;
        if (nv < 16) vdat[nv] = rd_data;
        nv++;
      end
      tick();
    end
    rd_req = 1'b0;
    chk("burst_acks", 32'(nack), 32'(8));
    chk("burst_first_valid", 32'(first_v), 32'(g0 + 5));
    chk("burst_nvalid", 32'(nv), 32'(8));
    for (int j = 0; j < 8; j++) chk("burst_data", 32'(vdat[j]), 32'(fdat(20'(j))));

    // Write after read with one turnaround cycle
    rd_req = 1'b1; rd_addr = 20'h00055;
    @(negedge clk);
    chk("war_rd_ack", 32'(rd_ack), 32'(1));
    tick();
    rd_req = 1'b0; wr_req = 1'b1; wr_addr = 20'hABCDE; wr_data = 18'h12345;
    @(negedge clk);
    chk("war_turn_ack", 32'(wr_ack), 32'(0));
    tick();
    @(negedge clk);
    chk("war_wr_ack", 32'(wr_ack), 32'(1));
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    chk("war_mem_we", 32'(mem_we), 32'(1));
    chk("war_mem_addr", 32'(mem_addr), 32'(20'hABCDE));
    chk("war_mem_wdata", 32'(mem_wdata), 32'(18'h12345));
    tick();
    repeat (6) tick();

    // Starvation bound with both requesters held high
    rd_req = 1'b1; rd_addr = 20'h00300; wr_req = 1'b1; wr_addr = 20'h00400; wr_data = 18'h00404;
    nwr = 0; run = 0; maxrun = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_ack) begin run++; if (run > maxrun) maxrun = run; end
      if (wr_ack) begin nwr++; runs.push_back(run); run = 0; end
      tick();
    end
    rd_req = 1'b0; wr_req = 1'b0;
    chk("starve_max_run", 32'(maxrun), 32'(8));
    chk("starve_wr_count", 32'(nwr), 32'(3));
    if (runs.size() > 1) chk("starve_run_between", 32'(runs[1]), 32'(8));
    else chk("starve_runs_recorded", 32'(runs.size()), 32'(2));
    repeat (4) tick();

    // Reset while reads are in flight
    do_read(20'h00010, g);
    do_read(20'h00011, g);
    do_read(20'h00012, g);
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_rd_valid", 32'(rd_valid), 32'(0));
    chk("postrst_rd_data", 32'(rd_data), 32'(0));
    chk("postrst_mem_addr", 32'(mem_addr), 32'(0));
    chk("postrst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("postrst_mem_we", 32'(mem_we), 32'(0));
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      if (rd_valid) vcnt++;
    end
    chk("postrst_dropped", 32'(vcnt), 32'(0));
    tick();
    do_read(20'h00777, g);
    first_v = -1;
    for (int k = 0; k < 10 && first_v < 0; k++) begin
      @(negedge clk);
      if (rd_valid) begin first_v = cyc; chk("postrst_read_data", 32'(rd_data), 32'(fdat(20'h00777))); end
      tick();
    end
    chk("postrst_read_latency", 32'(first_v), 32'(g + 5));

    // Randomized traffic
    rd_seen = 1'b1; wr_seen = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (!rd_req || rd_seen) begin
        rd_req = (k < 750) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) != 0);
        rd_addr = 20'($urandom);
      end
      if (!wr_req || wr_seen) begin
        wr_req = (k < 750) ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 3) == 0);
        wr_addr = 20'($urandom); wr_data = 18'($urandom);
      end
      rst = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      rd_seen = rd_ack; wr_seen = wr_ack;
      tick();
    end
    rst = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (8) tick();

    // Zero-turnaround instance: R, W, R on consecutive cycles
    b_rd_req = 1'b1; b_rd_addr = 20'h00001;
    @(negedge clk);
    chk("ta0_r1_ack", 32'(b_rd_ack), 32'(1));
    tick();
    b_rd_req = 1'b0; b_wr_req = 1'b1; b_wr_addr = 20'h00002; b_wr_data = 18'h00022;
    @(negedge clk);
    chk("ta0_w_ack", 32'(b_wr_ack), 32'(1));
    chk("ta0_w_rdack", 32'(b_rd_ack), 32'(0));
    tick();
    b_wr_req = 1'b0; b_rd_req = 1'b1; b_rd_addr = 20'h00003;
    @(negedge clk);
    chk("ta0_r2_ack", 32'(b_rd_ack), 32'(1));
    chk("ta0_mem_we", 32'(b_mem_we), 32'(1));
    chk("ta0_mem_addr", 32'(b_mem_addr), 32'(20'h00002));
    tick();
    b_rd_req = 1'b0;
    @(negedge clk);
    chk("ta0_r2_mem_addr", 32'(b_mem_addr), 32'(20'h00003));
    chk("ta0_r2_mem_we", 32'(b_mem_we), 32'(0));
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
